// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - synchronised, debounced request arbiter producing S/R drive pulses
module sr_drive_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int PULSE_W     = 2,
  parameter int GAP_W       = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic SET_REQ,
  input  logic CLR_REQ,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT,
  output logic DROPPED
);

  typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LD   = 4'((GAP_W > 0) ? GAP_W - 1 : 0);

  // Channel 0 carries the set request, channel 1 the clear request.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [7:0]             deb_cnt [2];
  logic [1:0]             deb_q;
  logic [1:0]             deb_d;
  logic [1:0]             ev;

  assign raw = {CLR_REQ, SET_REQ};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]  <= '0;
        deb_cnt[i] <= '0;
      end
      deb_q <= '0;
      deb_d <= '0;
    end else begin
      deb_d <= deb_q;
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        // Any cycle where the synced level agrees with the debounced one restarts the count.
        if (sync_q[i][SYNC_STAGES-1] != deb_q[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_q[i]   <= sync_q[i][SYNC_STAGES-1];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign ev = deb_q & ~deb_d;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       conflict_n, dropped_n;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    conflict_n = 1'b0;
    dropped_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ev == 2'b11) begin
          conflict_n = 1'b1;
        end else if (ev[0]) begin
          state_n = DRIVE_S;
          cnt_n   = PULSE_LD;
        end else if (ev[1]) begin
          state_n = DRIVE_R;
          cnt_n   = PULSE_LD;
        end
      end
      DRIVE_S, DRIVE_R: begin
        dropped_n = |ev;
        if (cnt == 4'd0) begin
          if (GAP_W > 0) begin
            state_n = GAP;
            cnt_n   = GAP_LD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      GAP: begin
        dropped_n = |ev;
        if (cnt == 4'd0) state_n = IDLE;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are true flops aligned with the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      BUSY     <= 1'b0;
      CONFLICT <= 1'b0;
      DROPPED  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      S        <= (state_n == DRIVE_S);
      R        <= (state_n == DRIVE_R);
      BUSY     <= (state_n != IDLE);
      CONFLICT <= conflict_n;
      DROPPED  <= dropped_n;
    end
  end

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Upstream command stage for sr_flipflop. Converts two raw, asynchronous, possibly bouncing request lines (set and reset) into clean, registered S/R drive pulses.
- Each request is synchronised and debounced, then edge-detected. Requests are arbitrated so S and R are never high together.
- S and R connect directly to the sr_flipflop S/R inputs on the same CLK.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per request input; legal range 2..4.
- DEBOUNCE, 4: consecutive stable cycles required before the debounced level changes; legal range 1..255.
- PULSE_W, 2: cycles S or R is held high per accepted request; legal range 1..15.
- GAP_W, 1: cycles of forced S=R=0 after each pulse before the next request is accepted; legal range 0..15.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SET_REQ  in  1  raw set request; asynchronous and may bounce.
- CLR_REQ  in  1  raw reset request; asynchronous and may bounce.
- S  out  1  registered set drive to sr_flipflop.
- R  out  1  registered reset drive to sr_flipflop.
- BUSY  out  1  high while state != IDLE.
- CONFLICT  out  1  one-cycle pulse: set and reset events arrived in the same cycle while IDLE.
- DROPPED  out  1  one-cycle pulse: a request event arrived while not IDLE and was discarded.

Behaviour:
- Reset (RST=1, asynchronous): all synchroniser, debounce, edge and FSM flops clear immediately.
  - Debounced levels = 0; state = IDLE.
  - S=R=BUSY=CONFLICT=DROPPED=0, held while RST=1.
  - Reset mid-pulse aborts the pulse with no completion.
- Synchroniser: SYNC_STAGES-deep chain per input; the last stage is the synced level.
- Debounce, per input:
  - 8-bit counter, reset 0.
  - If synced != debounced: counter increments. When it reaches DEBOUNCE, the debounced level takes the synced value and the counter clears.
  - If synced == debounced: counter clears, so any bounce restarts the count.
  - Counter never exceeds DEBOUNCE.
- Edge detect: event = debounced 0->1 transition, valid exactly one cycle. Falling edges generate nothing.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP. A 4-bit cycle counter is loaded on each state entry.
  - IDLE, set_ev & clr_ev: CONFLICT=1 next cycle; stay IDLE; no drive.
  - IDLE, set_ev only: go to DRIVE_S; S=1 from the next edge.
  - IDLE, clr_ev only: go to DRIVE_R; R=1 from the next edge.
  - DRIVE_S / DRIVE_R: hold S (or R) for exactly PULSE_W cycles. Then go to GAP if GAP_W>0, else to IDLE.
  - GAP: S=R=0 for exactly GAP_W cycles, then IDLE.
  - Any event while not IDLE: discarded; DROPPED=1 for one cycle (one pulse even if both events coincide). No queuing.
- Latency:
  - A clean raw rising edge first sampled at edge 1 gives S/R high after edge SYNC_STAGES+DEBOUNCE+1 (7 with defaults).
  - S/R are held for PULSE_W edges.
  - BUSY rises with S/R and falls at the IDLE entry edge.
- Invariant: S & R == 0 in every cycle, including reset release. The bench carries an assertion for this.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Clean set: CLK period 8, defaults; SET_REQ 0->1 held 100 time units -> S=1 from edge 7 for 2 cycles, R=0 throughout, BUSY=1 for 3 cycles, then IDLE.
- Bounce rejection: CLR_REQ toggles 1,0,1,0 at one-cycle intervals, then stays 1 -> no R pulse during the toggling; R=1 exactly SYNC_STAGES+DEBOUNCE+1 edges after the final stable rise; DEBOUNCE-1 stable cycles alone produce nothing.
- Conflict: SET_REQ and CLR_REQ rise in the same cycle -> CONFLICT=1 for one cycle at edge 7; S=R=0; BUSY stays 0.
- Drop while busy: set accepted, then CLR_REQ debounced event lands during DRIVE_S -> DROPPED=1 for one cycle; R never asserts; S pulse length unchanged (2).
- Back-to-back with GAP_W=0, PULSE_W=1: set event, then clr event on the cycle of IDLE re-entry -> S=1 for 1 cycle, then R=1 for 1 cycle, never overlapping.
- Async reset mid-pulse: assert RST halfway through the S=1 window -> S drops before the next CLK edge. After release, a still-high SET_REQ re-debounces and produces a fresh pulse 7 edges later.
